uart_rx: RTL and testbench

Receives 8-bit asynchronous serial frames (1 start, 8 data LSB-first, 1 stop) on the RX line and presents each byte with a ready flag. It is the receiving end of the team's UART link and is the counterpart of the existing transmitter. It uses the same bit period and frame format, so the two loop back directly. It reports framing and overrun errors for the host-side command logic.

---
 rtl/uart_pkg.sv | 15 +
 rtl/rx_sync.sv | 28 ++
 rtl/uart_rx.sv | 114 +++++++++++
 tb/tb_uart_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period and receiver state encoding.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DEF_BIT_CYC = 2605;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector.
// All flops reset to the idle (high) line level.
module rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
            prev <= rx_s;
        end
    end

    assign fall = prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, ready/ack handshake,
// framing and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BIT_CYC = DEF_BIT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr
);

    localparam logic [11:0] HALF   = 12'(BIT_CYC / 2);
    localparam logic [11:0] RELOAD = 12'(BIT_CYC - 1);

    uart_rx_state_t state;
    logic [11:0]    baud_cnt;
    logic [3:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           rx_s;
    logic           fall;
    logic           tick;

    rx_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (RX),
        .rx_s (rx_s),
        .fall (fall)
    );

    assign tick = (baud_cnt == 12'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy <= 1'b0;
                ovr <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (fall) begin
                        baud_cnt <= HALF;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        baud_cnt <= RELOAD;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 12'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        baud_cnt <= RELOAD;
                        shreg    <= {rx_s, shreg[7:1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 12'd1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        baud_cnt <= RELOAD;
                        if (rx_s) begin
                            // a completing frame overrides a same-cycle ack
                            rx_data <= shreg;
                            rdy     <= 1'b1;
                            ovr     <= clr_rdy ? ovr : (ovr | rdy);
                            frm_err <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            frm_err <= 1'b1;
                            state   <= BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 12'd1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx with a frame-level reference model.
// The bench plays the transmitter; a monitor checks every output change.
module tb_uart_rx;

    localparam int BC   = 41;
    localparam int HALF = BC / 2;
    // posedges from the first one seeing RX low to the flag update
    localparam int LAT  = HALF + 3 + 9 * BC;

    typedef struct packed {
        logic [7:0] data;
        logic       rdy;
        logic       frm;
        logic       ovr;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr;

    int   cyc = 0;
    int   t_p1 = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    obs_t model;
    obs_t last;
    obs_t expq[$];

    uart_rx #(.BIT_CYC(BC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .RX     (RX),
        .clr_rdy(clr_rdy),
        .rx_data(rx_data),
        .rdy    (rdy),
        .frm_err(frm_err),
        .ovr    (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Frame-level behaviour of the receiver's host-visible outputs
    function automatic obs_t after_frame(obs_t s, logic [7:0] b,
                                         bit stop_ok, bit clr);
        obs_t n = s;
        if (stop_ok) begin
            n.data = b;
            n.ovr  = clr ? s.ovr : (s.ovr | s.rdy);
            n.rdy  = 1'b1;
            n.frm  = 1'b0;
        end else begin
            n.frm = 1'b1;
        end
        return n;
    endfunction

    function automatic obs_t after_clr(obs_t s);
        obs_t n = s;
        n.rdy = 1'b0;
        n.ovr = 1'b0;
        return n;
    endfunction

    function automatic void model_set(obs_t n);
        if (n != model) expq.push_back(n);
        model = n;
    endfunction

    task automatic chk(string name, int got, int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t cur;
        obs_t e;
        if (mon_on) begin
            cur = {rx_data, rdy, frm_err, ovr};
            if (cur !== last) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got=%h", cur);
                end else begin
                    e = expq.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL outputs got d=%h r=%b f=%b o=%b want d=%h r=%b f=%b o=%b",
                                 cur.data, cur.rdy, cur.frm, cur.ovr,
                                 e.data, e.rdy, e.frm, e.ovr);
                    end
                end
                last = cur;
            end
        end
    end

    // Called just after a negedge; returns just after a negedge.
    task automatic send_frame(logic [7:0] b, logic stop, int extra_low);
        RX = 1'b0;
        t_p1 = cyc + 1;
        repeat (BC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BC) @(negedge clk);
        end
        RX = stop;
        repeat (BC) @(negedge clk);
        if (!stop) begin
            repeat (extra_low) @(negedge clk);
            RX = 1'b1;
            repeat (BC) @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        model_set(after_clr(model));
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    task automatic good(logic [7:0] b);
        model_set(after_frame(model, b, 1'b1, 1'b0));
        send_frame(b, 1'b1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data", rx_data, 0);
        chk("reset_rdy", rdy, 0);
        chk("reset_frm", frm_err, 0);
        chk("reset_ovr", ovr, 0);
        rst_n = 1'b1;
        model = '0;
        last = {rx_data, rdy, frm_err, ovr};
        mon_on = 1'b1;
        @(negedge clk);

        // Loopback byte with latency check
        model_set(after_frame(model, 8'hA5, 1'b1, 1'b0));
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (rdy !== 1'b1 && n < 12 * BC) begin
                    @(negedge clk);
                    n++;
                end
                chk("loopback_latency", cyc, t_p1 + LAT);
            end
        join
        pulse_clr();
        chk("clr_rdy_low", rdy, 0);

        // False start: glitch shorter than half a bit
        RX = 1'b0;
        repeat (10) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BC) @(negedge clk);

        // Framing error with a long break, then recovery
        model_set(after_frame(model, 8'h3C, 1'b0, 1'b0));
        send_frame(8'h3C, 1'b0, 2 * BC);
        chk("frm_err_set", frm_err, 1);
        chk("frm_rdy_low", rdy, 0);
        good(8'h5A);
        chk("recover_data", rx_data, 8'h5A);

        // Overrun
        pulse_clr();
        good(8'h11);
        good(8'h22);
        chk("ovr_set", ovr, 1);
        pulse_clr();
        chk("ovr_cleared", ovr, 0);

        // Completion coincident with clr_rdy
        good(8'h01);
        model_set(after_frame(model, 8'h02, 1'b1, 1'b1));
        fork
            send_frame(8'h02, 1'b1, 0);
            begin
                @(negedge clk);
                for (int k = 0; k < 12 * BC && cyc != t_p1 + LAT - 1; k++)
                    @(negedge clk);
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
            end
        join
        chk("simul_rdy", rdy, 1);
        chk("simul_ovr", ovr, 0);
        chk("simul_data", rx_data, 8'h02);

        // Reset during data bit 4 of a frame whose tail stays high
        fork
            send_frame(8'hF5, 1'b1, 0);
            begin
                @(negedge clk);
                for (int k = 0; k < 12 * BC && cyc != t_p1 + 5 * BC + HALF; k++)
                    @(negedge clk);
                rst_n = 1'b0;
                model_set('0);
                @(negedge clk);
                rst_n = 1'b1;
                chk("midrst_data", rx_data, 0);
                chk("midrst_rdy", rdy, 0);
            end
        join
        good(8'hC3);
        chk("after_rst_data", rx_data, 8'hC3);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            bit         ok;
            int         ext;
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 5) != 0);
            ext = ok ? 0 : int'($urandom_range(0, 2 * BC));
            model_set(after_frame(model, b, ok, 1'b0));
            send_frame(b, ok, ext);
            if ($urandom_range(0, 2) == 0) pulse_clr();
            repeat ($urandom_range(0, BC)) @(negedge clk);
        end

        repeat (BC) @(negedge clk);
        chk("pending_expected", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
